// File: rtl/turn_sw_conditioner_pkg.sv
// Shared defaults and helpers for the switch-input conditioning blocks.
// Also used by other switch-input blocks that need the debounce counter width.
package turn_sw_conditioner_pkg;

    localparam int unsigned PRESCALE_W_DEF  = 16;
    localparam int unsigned DEB_SAMPLES_DEF = 4;

    // Width of a counter that must reach DEB_SAMPLES-1.
    function automatic int unsigned deb_cnt_w(input int unsigned samples);
        return (samples <= 2) ? 1 : $clog2(samples);
    endfunction

endpackage

// File: rtl/turn_sw_conditioner_deb.sv
// deb_cell: 2-flop synchronizer followed by a tick-sampled counter debouncer.
// The level flips only after DEB_SAMPLES consecutive samples that differ from it.
module deb_cell
    import turn_sw_conditioner_pkg::*;
#(
    parameter int unsigned DEB_SAMPLES = DEB_SAMPLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic lvl
);

    localparam int unsigned    CW       = deb_cnt_w(DEB_SAMPLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_SAMPLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(negedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            lvl   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // A single sample agreeing with the current level restarts the count.
            if (tick) begin
                if (sync2 == lvl) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    lvl <= sync2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/turn_sw_conditioner.sv
// Conditions raw turn switches and hazard button into clean l/r/halt levels
// for the taillight sequencer; all state moves on negedge clk like the sequencer.
module turn_sw_conditioner
    import turn_sw_conditioner_pkg::*;
#(
    parameter int unsigned PRESCALE_W  = PRESCALE_W_DEF,
    parameter int unsigned DEB_SAMPLES = DEB_SAMPLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_l_raw,
    input  logic sw_r_raw,
    input  logic btn_haz_raw,
    output logic l,
    output logic r,
    output logic halt,
    output logic tick
);

    logic [PRESCALE_W-1:0] pre;
    logic                  deb_l;
    logic                  deb_r;
    logic                  deb_btn;
    logic                  deb_btn_q;
    logic                  haz;
    logic                  halt_nxt;

    always_ff @(negedge clk) begin
        if (rst) begin
            pre  <= '0;
            tick <= 1'b0;
        end else begin
            pre  <= pre + 1'b1;
            tick <= (pre == '1);
        end
    end

    deb_cell #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_l (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .raw  (sw_l_raw),
        .lvl  (deb_l)
    );

    deb_cell #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_r (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .raw  (sw_r_raw),
        .lvl  (deb_r)
    );

    deb_cell #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_btn (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .raw  (btn_haz_raw),
        .lvl  (deb_btn)
    );

    // Toggle only on the debounced press edge; holding or releasing does nothing.
    always_ff @(negedge clk) begin
        if (rst) begin
            deb_btn_q <= 1'b0;
            haz       <= 1'b0;
        end else begin
            deb_btn_q <= deb_btn;
            if (deb_btn && !deb_btn_q) begin
                haz <= ~haz;
            end
        end
    end

    always_comb begin
        halt_nxt = haz | (deb_l & deb_r);
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            l    <= 1'b0;
            r    <= 1'b0;
            halt <= 1'b0;
        end else begin
            halt <= halt_nxt;
            l    <= deb_l & ~halt_nxt;
            r    <= deb_r & ~halt_nxt;
        end
    end

endmodule
